arc4_sched: RTL and testbench
=============================

# arc4_sched

Top-level sequencer for one ARC4 decryption pass. It accepts a 24-bit key over an `en`/`rdy` handshake and starts the `init`, `ksa` and `prga` engines in that order, one at a time. While each engine runs, the block grants it the single shared S-memory write/address port. It also holds the key stable for the engines and flags an error if any engine fails to finish within a watchdog limit.

## Interface
Parameters:
- `TIMEOUT`, default 65535: maximum cycles allowed per engine phase; 16-bit range, must be ≥ 2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: start pulse from the caller; sampled only while `rdy`=1.
- `rdy` out 1: block idle and able to accept `en`.
- `err` out 1: last pass aborted by the watchdog.
- `phase` out 2: 0 idle/done, 1 init, 2 ksa, 3 prga.
- `key` in 24: key, captured when `en` is accepted.
- `key_q` out 24: captured key, driven to `ksa` and `prga`.
- `init_en` out 1, `init_rdy` in 1: handshake with the init engine.
- `ksa_en` out 1, `ksa_rdy` in 1: handshake with the ksa engine.
- `prga_en` out 1, `prga_rdy` in 1: handshake with the prga engine.
- `init_s_addr` in 8, `init_s_wrdata` in 8, `init_s_wren` in 1: init engine's S-port request.
- `ksa_s_addr` in 8, `ksa_s_wrdata` in 8, `ksa_s_wren` in 1: ksa engine's S-port request.
- `prga_s_addr` in 8, `prga_s_wrdata` in 8, `prga_s_wren` in 1: prga engine's S-port request.
- `s_addr` out 8, `s_wrdata` out 8, `s_wren` out 1: muxed S-memory port. `s_rddata` goes from memory to all engines directly and does not pass through this block.

## Operation
States: IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA, ERR.

State transitions:
- IDLE: `rdy`=1. On `en`=1, latch `key` into `key_q`, clear `err`, and go to START_INIT.
- START_x: wait in this state until `x_rdy`=1. In the cycle where `x_rdy`=1, `x_en`=1 (combinational: state is START_x and `x_rdy`=1), then go to WAIT_x. `x_en` is therefore exactly one cycle wide.
- WAIT_x, first cycle: blanking cycle; `x_rdy` is ignored.
- WAIT_x, later cycles: on `x_rdy`=1, move to the next START state. After WAIT_PRGA, return to IDLE.
- Watchdog: a 16-bit counter clears when START_x is entered and increments every cycle in START_x and WAIT_x. When it reaches `TIMEOUT` before the phase completes, go to ERR.
- ERR: `rdy`=1, `err`=1, all engine enables low. On `en`=1, behave as IDLE does: latch the key, clear `err`, go to START_INIT.
- `en` is ignored in every state other than IDLE and ERR.

S-port grant (combinational from state):
- START_INIT/WAIT_INIT: port driven from the `init_*` inputs.
- START_KSA/WAIT_KSA: port driven from the `ksa_*` inputs.
- START_PRGA/WAIT_PRGA: port driven from the `prga_*` inputs.
- IDLE/ERR: `s_addr`=0, `s_wrdata`=0, `s_wren`=0.
- A non-granted engine's `wren` never reaches memory.

`phase` mapping:
- 1 in INIT states, 2 in KSA states, 3 in PRGA states, 0 otherwise.

## Timing
- Reset values: `rdy`=1, `err`=0, `phase`=0, `key_q`=0, all `*_en`=0, `s_wren`=0, `s_addr`=0, `s_wrdata`=0, state IDLE, watchdog counter 0.
- Reset asserted mid-pass: all outputs return to reset values immediately. An engine in progress is abandoned, and S writes stop in the same cycle.
- Handshake: `en` is accepted at edge N. `rdy`=0 from N+1. `init_en` goes high in cycle N+1 if `init_rdy`=1.
- Phase-to-phase overhead: `x_rdy` rises in cycle M (after the blanking cycle). The next engine's `en` is asserted in cycle M+1 at the earliest.
- Total latency with always-ready engines of busy lengths Li, Lk, Lp (engine drops `rdy` for L cycles after its `en`): `rdy` returns high exactly Li+Lk+Lp+4 cycles after the accepting edge.
- `key_q` changes only on accepting edges. It is stable throughout the pass.
- Grant switches on the same edge as the state change. There is no dead cycle beyond the START cycle itself.

## Test plan
- Normal pass: stub engines with L=3/5/7, `key`=24'h00033C, pulse `en` → `init_en`, `ksa_en`, `prga_en` each fire exactly once and in order; `phase` goes 1→2→3→0; `rdy` is high again 19 cycles after acceptance; `key_q`=24'h00033C.
- Busy `en`: pulse `en` with `key`=24'h1 during WAIT_KSA → ignored; `key_q` unchanged; no restart; one complete pass only.
- Stall: hold `ksa_rdy`=0 for 10 cycles on entry to START_KSA → `ksa_en` stays low for those 10 cycles, then pulses once for one cycle.
- Mux: drive `ksa_s_wren`=1, `ksa_s_addr`=8'h5A and `prga_s_wren`=1 throughout → `s_wren` follows ksa only in KSA states; `s_addr`=8'h5A there; `s_wren`=0 in IDLE.
- Watchdog: `TIMEOUT`=16, `prga_rdy` stuck at 0 → ERR after 16 cycles in the PRGA phase; `err`=1, `rdy`=1, `phase`=0. A new `en` clears `err` and runs a full pass.
- Reset mid-KSA: assert `rst_n`=0 between clock edges → asynchronous return to all reset values; after release, `en` starts a clean pass.

Source files
------------

// File: rtl/arc4_sched.sv
// arc4_sched: runs init -> ksa -> prga for one ARC4 pass, owns the shared
// S-memory port grant, holds the captured key and watches each phase for a hang.
//
// state      | meaning
// IDLE       | waiting for en, rdy=1
// START_INIT | waiting for init_rdy, pulses init_en when seen
// WAIT_INIT  | init running; first cycle ignores init_rdy
// START_KSA  | waiting for ksa_rdy, pulses ksa_en when seen
// WAIT_KSA   | ksa running; first cycle ignores ksa_rdy
// START_PRGA | waiting for prga_rdy, pulses prga_en when seen
// WAIT_PRGA  | prga running; first cycle ignores prga_rdy
// ERR        | watchdog expired; rdy=1, err=1, accepts en like IDLE
module arc4_sched #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic        err,
  output logic [1:0]  phase,
  input  logic [23:0] key,
  output logic [23:0] key_q,
  output logic        init_en,
  input  logic        init_rdy,
  output logic        ksa_en,
  input  logic        ksa_rdy,
  output logic        prga_en,
  input  logic        prga_rdy,
  input  logic [7:0]  init_s_addr,
  input  logic [7:0]  init_s_wrdata,
  input  logic        init_s_wren,
  input  logic [7:0]  ksa_s_addr,
  input  logic [7:0]  ksa_s_wrdata,
  input  logic        ksa_s_wren,
  input  logic [7:0]  prga_s_addr,
  input  logic [7:0]  prga_s_wrdata,
  input  logic        prga_s_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  typedef enum logic [2:0] {
    IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA, ERR
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wdog_cnt;
  logic        blank;
  logic        active;
  logic        phase_done;
  logic        wdog_exp;
  logic        accept;
  logic        enter_start;

  assign active   = (state != IDLE) && (state != ERR);
  assign wdog_exp = (wdog_cnt == WDOG_LAST);
  assign accept   = ((state == IDLE) || (state == ERR)) && en;
  assign enter_start = (state_nxt != state) &&
                       (state_nxt inside {START_INIT, START_KSA, START_PRGA});
  assign phase_done = !blank && (((state == WAIT_INIT) && init_rdy) ||
                                 ((state == WAIT_KSA)  && ksa_rdy)  ||
                                 ((state == WAIT_PRGA) && prga_rdy));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ERR:  if (en)                 state_nxt = START_INIT;
      START_INIT: if (init_rdy)           state_nxt = WAIT_INIT;
      WAIT_INIT:  if (init_rdy && !blank) state_nxt = START_KSA;
      START_KSA:  if (ksa_rdy)            state_nxt = WAIT_KSA;
      WAIT_KSA:   if (ksa_rdy && !blank)  state_nxt = START_PRGA;
      START_PRGA: if (prga_rdy)           state_nxt = WAIT_PRGA;
      WAIT_PRGA:  if (prga_rdy && !blank) state_nxt = IDLE;
    endcase
    // A phase that finishes in its last allowed cycle still completes.
    if (active && wdog_exp && !phase_done) state_nxt = ERR;
  end

  always_comb begin
    rdy      = 1'b0;
    err      = 1'b0;
    phase    = 2'd0;
    init_en  = 1'b0;
    ksa_en   = 1'b0;
    prga_en  = 1'b0;
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    unique case (state)
      IDLE: rdy = 1'b1;
      ERR: begin
        rdy = 1'b1;
        err = 1'b1;
      end
      START_INIT, WAIT_INIT: begin
        phase    = 2'd1;
        init_en  = (state == START_INIT) && init_rdy;
        s_addr   = init_s_addr;
        s_wrdata = init_s_wrdata;
        s_wren   = init_s_wren;
      end
      START_KSA, WAIT_KSA: begin
        phase    = 2'd2;
        ksa_en   = (state == START_KSA) && ksa_rdy;
        s_addr   = ksa_s_addr;
        s_wrdata = ksa_s_wrdata;
        s_wren   = ksa_s_wren;
      end
      START_PRGA, WAIT_PRGA: begin
        phase    = 2'd3;
        prga_en  = (state == START_PRGA) && prga_rdy;
        s_addr   = prga_s_addr;
        s_wrdata = prga_s_wrdata;
        s_wren   = prga_s_wren;
      end
    endcase
  end

  // blank marks the first WAIT cycle, where the engine's rdy is still stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= 16'd0;
      blank    <= 1'b0;
      key_q    <= 24'd0;
    end else begin
      blank <= init_en || ksa_en || prga_en;
      if (enter_start)  wdog_cnt <= 16'd0;
      else if (active)  wdog_cnt <= wdog_cnt + 16'd1;
      if (accept)       key_q <= key;
    end
  end

endmodule

// File: tb/tb_arc4_sched.sv
// Directed + randomized bench for arc4_sched; stub engines and a timeline model
// of each pass (start/enable/finish cycles per phase) predict every output.
module tb_arc4_sched;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic        err;
  logic [1:0]  phase;
  logic [23:0] key;
  logic [23:0] key_q;
  logic        init_en, ksa_en, prga_en;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  init_s_addr, init_s_wrdata, ksa_s_addr, ksa_s_wrdata, prga_s_addr, prga_s_wrdata;
  logic        init_s_wren, ksa_s_wren, prga_s_wren;
  logic [7:0]  s_addr, s_wrdata;
  logic        s_wren;

  arc4_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .err(err), .phase(phase),
    .key(key), .key_q(key_q),
    .init_en(init_en), .init_rdy(init_rdy),
    .ksa_en(ksa_en), .ksa_rdy(ksa_rdy),
    .prga_en(prga_en), .prga_rdy(prga_rdy),
    .init_s_addr(init_s_addr), .init_s_wrdata(init_s_wrdata), .init_s_wren(init_s_wren),
    .ksa_s_addr(ksa_s_addr), .ksa_s_wrdata(ksa_s_wrdata), .ksa_s_wren(ksa_s_wren),
    .prga_s_addr(prga_s_addr), .prga_s_wrdata(prga_s_wrdata), .prga_s_wren(prga_s_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int t_cur = 0;
  int m_ts[3], m_te[3], m_end[3];
  int m_last;
  bit m_err;
  logic [23:0] kq;
  int busy_c[3], stall_c[3];
  int sv[3], lv[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t_cur, obs, exp);
  endtask

  // Timeline of one pass: phase x occupies cycles [m_ts, m_end); a phase needs
  // s+1 START cycles plus l WAIT cycles and must fit in TO cycles.
  task automatic model(input int s[3], input int l[3]);
    int t;
    t = 1;
    m_err = 1'b0;
    for (int x = 0; x < 3; x++) begin
      m_ts[x] = 0; m_te[x] = -1; m_end[x] = 0;
    end
    for (int x = 0; x < 3; x++) begin
      m_ts[x] = t;
      if (s[x] + 1 + l[x] > TO) begin
        m_err = 1'b1;
        t = t + TO;
        m_end[x] = t;
        break;
      end
      m_te[x] = t + s[x];
      t = m_te[x] + l[x] + 1;
      m_end[x] = t;
    end
    m_last = t;
  endtask

  function automatic logic [1:0] exp_phase(input int t);
    exp_phase = 2'd0;
    for (int x = 0; x < 3; x++)
      if (t >= m_ts[x] && t < m_end[x]) exp_phase = 2'(x + 1);
  endfunction

  task automatic drive_s(input bit fixed);
    if (fixed) begin
      init_s_addr = 8'h11; init_s_wrdata = 8'h22; init_s_wren = 1'b0;
      ksa_s_addr  = 8'h5A; ksa_s_wrdata  = 8'hA5; ksa_s_wren  = 1'b1;
      prga_s_addr = 8'hC3; prga_s_wrdata = 8'h3C; prga_s_wren = 1'b1;
    end else begin
      init_s_addr = 8'($urandom); init_s_wrdata = 8'($urandom); init_s_wren = 1'($urandom);
      ksa_s_addr  = 8'($urandom); ksa_s_wrdata  = 8'($urandom); ksa_s_wren  = 1'($urandom);
      prga_s_addr = 8'($urandom); prga_s_wrdata = 8'($urandom); prga_s_wren = 1'($urandom);
    end
  endtask

  task automatic stub_drive();
    init_rdy = (stall_c[0] == 0) && (busy_c[0] == 0);
    ksa_rdy  = (stall_c[1] == 0) && (busy_c[1] == 0);
    prga_rdy = (stall_c[2] == 0) && (busy_c[2] == 0);
  endtask

  task automatic check_cycle(input int t);
    logic [1:0] ep;
    logic [7:0] ea, ed;
    logic       ew;
    ep = exp_phase(t);
    chk("phase", 32'(phase), 32'(ep));
    chk("rdy", 32'(rdy), 32'(t >= m_last));
    chk("err", 32'(err), 32'(m_err && t >= m_last));
    chk("init_en", 32'(init_en), 32'(t == m_te[0]));
    chk("ksa_en", 32'(ksa_en), 32'(t == m_te[1]));
    chk("prga_en", 32'(prga_en), 32'(t == m_te[2]));
    chk("key_q", 32'(key_q), 32'(kq));
    case (ep)
      2'd1:    begin ea = init_s_addr; ed = init_s_wrdata; ew = init_s_wren; end
      2'd2:    begin ea = ksa_s_addr;  ed = ksa_s_wrdata;  ew = ksa_s_wren;  end
      2'd3:    begin ea = prga_s_addr; ed = prga_s_wrdata; ew = prga_s_wren; end
      default: begin ea = 8'd0; ed = 8'd0; ew = 1'b0; end
    endcase
    chk("s_addr", 32'(s_addr), 32'(ea));
    chk("s_wrdata", 32'(s_wrdata), 32'(ed));
    chk("s_wren", 32'(s_wren), 32'(ew));
  endtask

  // ien_t: cycle of an extra en pulse (key=1) that must be ignored; -1 picks one.
  // rst_t: cycle at which reset is asserted between edges (0 = none).
  task automatic run_pass(input logic [23:0] k, input int s[3], input int l[3],
                          input int ien_t, input int rst_t, input bit fixed);
    logic [1:0] ph;
    logic [2:0] ens;
    int rdy_t;
    int ien;
    model(s, l);
    ien = (ien_t < 0) ? int'($urandom_range(1, m_last - 1)) : ien_t;
    @(negedge clk);
    for (int x = 0; x < 3; x++) begin
      stall_c[x] = s[x];
      busy_c[x]  = 0;
    end
    stub_drive();
    key = k;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    key = 24'($urandom);
    kq  = k;
    rdy_t = 0;
    for (int t = 1; t <= m_last; t++) begin
      t_cur = t;
      drive_s(fixed);
      if (t == ien) begin
        en  = 1'b1;
        key = 24'h000001;
      end
      @(negedge clk);
      if (t == rst_t) begin
        drive_s(1'b1);
        rst_n = 1'b0;
        #1;
        kq = 24'd0;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_key_q", 32'(key_q), 32'd0);
        chk("rst_en", 32'({prga_en, ksa_en, init_en}), 32'd0);
        chk("rst_s_wren", 32'(s_wren), 32'd0);
        chk("rst_s_addr", 32'(s_addr), 32'd0);
        chk("rst_s_wrdata", 32'(s_wrdata), 32'd0);
        en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      check_cycle(t);
      if (rdy && rdy_t == 0) rdy_t = t;
      ph  = phase;
      ens = {prga_en, ksa_en, init_en};
      if (t == m_last) break;
      @(posedge clk);
      #1;
      en = 1'b0;
      for (int x = 0; x < 3; x++) begin
        if (ens[x]) busy_c[x] = l[x] - 1;
        else if (busy_c[x] > 0) busy_c[x]--;
        if (ph == 2'(x + 1) && stall_c[x] > 0) stall_c[x]--;
      end
      stub_drive();
    end
    chk("rdy_return_cycle", 32'(rdy_t), 32'(m_last));
  endtask

  initial begin
    en = 1'b0;
    key = 24'd0;
    for (int x = 0; x < 3; x++) begin
      stall_c[x] = 0;
      busy_c[x]  = 0;
    end
    stub_drive();
    drive_s(1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    kq = 24'd0;
    sv = '{0, 0, 0};
    lv = '{3, 3, 3};
    model(sv, lv);
    m_last = 0;
    for (int x = 0; x < 3; x++) begin
      m_ts[x] = 0; m_te[x] = -1; m_end[x] = 0;
    end
    t_cur = 0;
    check_cycle(0);
    rst_n = 1'b1;

    // Normal pass, L=3/5/7, fixed S-port requests for the mux checks.
    sv = '{0, 0, 0}; lv = '{3, 5, 7};
    run_pass(24'h00033C, sv, lv, 0, 0, 1'b1);
    // en with key=1 during WAIT_KSA must be ignored.
    run_pass(24'hABCDEF, sv, lv, 7, 0, 1'b0);
    // ksa_rdy held low for 10 cycles on entry to START_KSA.
    sv = '{0, 10, 0}; lv = '{3, 3, 3};
    run_pass(24'h123456, sv, lv, 0, 0, 1'b1);
    // prga never ready: watchdog fires after TO cycles in the PRGA phase.
    sv = '{0, 0, 100}; lv = '{3, 3, 3};
    run_pass(24'h0F0F0F, sv, lv, 0, 0, 1'b1);
    // Recovery from ERR with a full pass.
    sv = '{1, 2, 0}; lv = '{4, 2, 6};
    run_pass(24'h777777, sv, lv, 0, 0, 1'b0);
    // Reset mid-KSA, then a clean pass.
    sv = '{0, 0, 0}; lv = '{3, 5, 7};
    run_pass(24'hC0FFEE, sv, lv, 0, 7, 1'b1);
    run_pass(24'h00033C, sv, lv, 0, 0, 1'b0);
    // Randomized passes with random stalls, busy lengths and ignored en pulses.
    for (int i = 0; i < 8; i++) begin
      for (int x = 0; x < 3; x++) begin
        sv[x] = int'($urandom_range(0, 4));
        lv[x] = int'($urandom_range(2, 8));
      end
      run_pass(24'($urandom), sv, lv, -1, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
